// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
package instr_fetch_stage_pkg;

  localparam int          XLEN_DEF = 32;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID output register: flush beats load, load beats drain, otherwise hold.
module instr_fetch_stage_if_id_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic            drain,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_in;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// RISC-V fetch stage: PC, single-outstanding imem request, redirect/flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect target traps and halts fetch.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int            XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] fetch_bad_addr
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc, req_pc, tgt;
  logic            drop, blocked, req_fire, rsp_fire, load;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt     = redirect_pc;
  assign blocked = fetch_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
      fetch_bad_addr   <= '0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fetch_misaligned <= 1'b1;
      fetch_bad_addr   <= redirect_pc;
    end
  end
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^redirect_pc[1:0];
  assign tgt     = {redirect_pc[XLEN-1:2], 2'b00};
  assign blocked = 1'b0;
`endif

  // Issue only when the IF/ID slot is free or draining, so a response always fits.
  assign imem_req_valid = (state == REQ) && (!id_valid || id_ready) && !redirect_valid && !blocked;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = (state == WAIT) && imem_rsp_valid;
  assign load           = rsp_fire && !drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      state  <= REQ;
      drop   <= 1'b0;
    end else if (redirect_valid) begin
      pc <= tgt;
      // An in-flight request becomes wrong-path; retire it now or mark it for discard.
      if (state == WAIT) begin
        if (imem_rsp_valid) begin
          drop  <= 1'b0;
          state <= REQ;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      if (req_fire) begin
        req_pc <= pc;
        pc     <= pc + XLEN'(PC_STEP);
        state  <= WAIT;
      end
      if (rsp_fire) begin
        drop  <= 1'b0;
        state <= REQ;
      end
    end
  end

  instr_fetch_stage_if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .load    (load),
    .drain   (id_ready),
    .inst_in (imem_rsp_data),
    .pc_in   (req_pc),
    .valid   (id_valid),
    .inst    (id_inst),
    .pc      (id_pc)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench: every accepted fetch since the last redirect/reset must reach decode in order.
module tb_instr_fetch_stage;
  import instr_fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready, id_valid;
  logic [31:0] id_inst, id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic [31:0] fetch_bad_addr;
`endif

  always #5 clk = ~clk;

  instr_fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned),
    .fetch_bad_addr   (fetch_bad_addr)
`endif
  );

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id_valid) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_valid: timeout, id_valid never rose");
  endtask

  task automatic wait_accept(output logic [31:0] addr);
    addr = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && !reset) begin
        addr = imem_addr;
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL wait_accept: timeout, no request accepted");
  endtask

  // Instruction memory: one response per accepted request after lat cycles.
  logic        m_acc, m_rst, m_pend;
  logic [31:0] m_addr, m_paddr;
  int          m_cnt;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    m_pend = 1'b0;
    m_cnt  = 0;
    forever begin
      @(negedge clk);
      m_acc  = imem_req_valid && imem_req_ready && !reset;
      m_addr = imem_addr;
      m_rst  = reset;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (m_rst) m_pend = 1'b0;
      if (m_acc) begin
        m_pend  = 1'b1;
        m_paddr = m_addr;
        m_cnt   = int'($urandom_range(lat_max, lat_min));
      end
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(m_paddr);
          m_pend = 1'b0;
        end
      end
    end
  end

  // Reference model: PC sequence and expected deliveries.
  logic [31:0] mpc = RST_PC;
  logic        trapped = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (trapped && !reset) chk("no_req_after_trap", 32'(imem_req_valid), 32'h0);
      if (reset) begin
        q.delete();
        mpc = RST_PC;
        trapped = 1'b0;
      end else if (redirect_valid) begin
        chk("no_req_on_redirect", 32'(imem_req_valid), 32'h0);
        q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) trapped = 1'b1;
        mpc = redirect_pc;
`else
        mpc = redirect_pc & ~32'h3;
`endif
      end else if (imem_req_valid && imem_req_ready) begin
        chk("imem_addr", imem_addr, mpc);
        q.push_back(exp_t'{pc: mpc, inst: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Monitor: delivery and stall-hold checks.
  logic        hold_p = 1'b0;
  logic [31:0] h_pc, h_inst;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk);
      if (hold_p) begin
        chk("stall_hold_valid", 32'(id_valid), 32'h1);
        chk("stall_hold_pc", id_pc, h_pc);
        chk("stall_hold_inst", id_inst, h_inst);
      end
      if (!reset && !redirect_valid && id_valid && id_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_delivery: got pc %h inst %h expected none", id_pc, id_inst);
        end else begin
          e = q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_inst", id_inst, e.inst);
        end
      end
      hold_p = !reset && !redirect_valid && id_valid && !id_ready;
      if (hold_p) chk("no_req_while_stalled", 32'(imem_req_valid), 32'h0);
      h_pc   = id_pc;
      h_inst = id_inst;
    end
  end

  logic [31:0] a;
  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_inst", id_inst, NOP_INST);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);

    // First instruction two cycles after reset release with a 1-cycle memory.
    tick(); reset = 1'b0;
    @(negedge clk); chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    tick(); @(negedge clk); chk("lat_edge1_valid", 32'(id_valid), 32'h0);
    tick(); @(negedge clk); chk("lat_edge2_valid", 32'(id_valid), 32'h1);
    chk("first_id_pc", id_pc, 32'h0);
    chk("first_id_inst", id_inst, 32'h0050_0093);
    tick(); tick(); @(negedge clk);
    chk("second_id_pc", id_pc, 32'h4);
    chk("second_id_inst", id_inst, 32'h00A0_0113);
    repeat (4) tick();

    // Stall for 5 cycles with a valid instruction held.
    id_ready = 1'b0;
    wait_valid();
    repeat (5) tick();
    id_ready = 1'b1;
    repeat (6) tick();

    // Redirect while waiting on a slow response.
    lat_min = 3; lat_max = 3;
    wait_accept(a);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_accept(a);
    chk("redir_wait_addr", a, 32'h100);
    wait_valid();
    chk("redir_wait_first_pc", id_pc, 32'h100);

    // Redirect in the same cycle as the response.
    lat_min = 1; lat_max = 1;
    tick();
    wait_accept(a);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk); chk("redir_rsp_flush", 32'(id_valid), 32'h0);
    wait_valid();
    chk("redir_rsp_first_pc", id_pc, 32'h40);

    // PC wrap.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_accept(a); chk("wrap_addr0", a, 32'hFFFF_FFFC);
    tick();
    wait_accept(a); chk("wrap_addr1", a, 32'h0);

    // Reset while a response is arriving.
    tick();
    wait_accept(a);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_id_valid", 32'(id_valid), 32'h0);
    chk("rst_wait_addr", imem_addr, RST_PC);
    repeat (4) tick();

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("trap_flag", 32'(fetch_misaligned), 32'h1);
    chk("trap_addr", fetch_bad_addr, 32'h102);
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("trap_cleared", 32'(fetch_misaligned), 32'h0);
`else
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    wait_accept(a);
    chk("misalign_masked_addr", a, 32'h100);
`endif

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 2500; i++) begin
      tick();
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc[1:0] = 2'b00;
`endif
      reset          = ($urandom_range(0, 299) == 0);
    end
    tick();
    redirect_valid = 1'b0; reset = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
